multicycle_control: RTL and testbench

//  Moore-FSM control unit for the multicycle MIPS datapath; it replaces the single-cycle opcode decoder.

---
 rtl/mips_pkg.sv | 80 ++++++++
 rtl/multicycle_control.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALU
// operation codes, FSM state encoding and datapath mux encodings.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [3:0] ALU_J    = 4'b0001;
  localparam logic [3:0] ALU_JAL  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ANDI = 4'b0101;
  localparam logic [3:0] ALU_ORI  = 4'b0110;
  localparam logic [3:0] ALU_R    = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;
  localparam logic [3:0] ALU_LW   = 4'b1010;
  localparam logic [3:0] ALU_SW   = 4'b1011;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // 4-bit ALU operation for a latched opcode; unknown opcodes never reach
  // the states that use this, so they map to 0.
  function automatic logic [3:0] alu_code(input logic [5:0] opc);
    case (opc)
      OP_R:    alu_code = ALU_R;
      OP_ADDI: alu_code = ALU_ADD;
      OP_ANDI: alu_code = ALU_ANDI;
      OP_ORI:  alu_code = ALU_ORI;
      OP_LUI:  alu_code = ALU_LUI;
      OP_BEQ:  alu_code = ALU_BEQ;
      OP_BNE:  alu_code = ALU_BNE;
      OP_LW:   alu_code = ALU_LW;
      OP_SW:   alu_code = ALU_SW;
      OP_J:    alu_code = ALU_J;
      OP_JAL:  alu_code = ALU_JAL;
      default: alu_code = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM for the multicycle MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback, waits on mem_ready and traps on an
// illegal opcode or a memory access that never completes.
//
//  state      | meaning
//  S_IDLE     | post-reset, nothing driven
//  S_FETCH    | instruction read at PC, PC+4 computed; IR/PC load on mem_ready
//  S_DECODE   | opcode latched, branch target computed into ALUOut
//  S_EXEC     | ALU op for R-type / immediate instructions
//  S_ALU_WB   | ALU result written to register file
//  S_MEM_ADDR | effective address computation for LW/SW
//  S_MEM_RD   | data read, waiting on mem_ready
//  S_MEM_WB   | loaded data written to register file
//  S_MEM_WR   | data write, waiting on mem_ready
//  S_BRANCH   | conditional PC load from ALUOut
//  S_JUMP     | PC load from jump target (JAL also links $ra)
//  S_TRAP     | absorbing error state, left only by reset
module multicycle_control
  import mips_pkg::*;
#(
  parameter int ALUOP_WIDTH = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_beq,
  output logic                   pc_write_bne,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic [1:0]             reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   instr_done,
  output logic                   trap,
  output logic [1:0]             trap_cause
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST =
    CNT_WIDTH'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic   [5:0]           r_op_q;
  logic   [CNT_WIDTH-1:0] r_wait_cnt;
  logic   [1:0]           r_trap_cause;
  logic   [1:0]           w_next_cause;
  logic                   w_is_wait;
  logic                   w_timeout;
  logic   [3:0]           w_alu_code;

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                     (r_state == S_MEM_WR);
  // Timeout fires only while still waiting; a completing access wins.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_is_wait && !mem_ready &&
                     (r_wait_cnt == LP_CNT_LAST);

  // Next-state and trap-cause selection
  always_comb begin
    w_next_state = r_state;
    w_next_cause = CAUSE_NONE;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_EXEC;
          OP_LW, OP_SW:                           w_next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                         w_next_state = S_BRANCH;
          OP_J, OP_JAL:                           w_next_state = S_JUMP;
          default: begin
            w_next_state = S_TRAP;
            w_next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC:     w_next_state = S_ALU_WB;
      S_ALU_WB:   w_next_state = S_FETCH;
      S_MEM_ADDR: w_next_state = (r_op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          w_next_state = S_MEM_WB;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next_state = S_FETCH;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // State, latched opcode, wait counter and trap cause registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op_q       <= 6'd0;
      r_wait_cnt   <= '0;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op_q <= op;
      end
      // Counting only while staying in the same wait state clears the count
      // both on entry and when an access completes.
      if (w_is_wait && (w_next_state == r_state)) begin
        r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap_cause <= w_next_cause;
      end
    end
  end

  // Output decode from the state register (mem_ready only qualifies completion pulses)
  always_comb begin
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = REG_DST_RT;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_RT;
    pc_source    = PC_SRC_ALU;
    w_alu_code   = 4'b0000;
    instr_done   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        w_alu_code = ALU_ADD;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_IMM_SH2;
        w_alu_code = ALU_ADD;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = (r_op_q == OP_R) ? SRC_B_RT : SRC_B_IMM;
        w_alu_code = alu_code(r_op_q);
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (r_op_q == OP_R) ? REG_DST_RD : REG_DST_RT;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        w_alu_code = alu_code(r_op_q);
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        w_alu_code   = alu_code(r_op_q);
        pc_source    = PC_SRC_ALUOUT;
        pc_write_beq = (r_op_q == OP_BEQ);
        pc_write_bne = (r_op_q == OP_BNE);
        instr_done   = 1'b1;
      end
      S_JUMP: begin
        pc_source  = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (r_op_q == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = REG_DST_RA;
        end
      end
      default: ;
    endcase
  end

  assign alu_op     = ALUOP_WIDTH'(w_alu_code);
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors
// for each instruction class, wait/timeout behaviour and reset.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, alu_src_a, instr_done, trap;
  logic [1:0] reg_dst, alu_src_b, pc_source, trap_cause;
  logic [3:0] alu_op;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;
  } out_t;

  out_t obs;
  out_t q_ex[$];
  logic q_rd[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_control #(.ALUOP_WIDTH(4), .MEM_TIMEOUT(16), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .instr_done(instr_done),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign obs = {pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                pc_source, alu_op, instr_done, trap, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors, one per state, written from the control table.
  function automatic out_t v_idle();
    out_t v = '0;
    return v;
  endfunction
  function automatic out_t v_fetch(input logic rdy);
    out_t v = '0;
    v.mem_read = 1'b1; v.alu_src_b = 2'd1; v.alu_op = 4'b0100;
    v.ir_write = rdy;  v.pc_write = rdy;
    return v;
  endfunction
  function automatic out_t v_decode();
    out_t v = '0;
    v.alu_src_b = 2'd3; v.alu_op = 4'b0100;
    return v;
  endfunction
  function automatic out_t v_exec(input logic [3:0] code, input logic [1:0] srcb);
    out_t v = '0;
    v.alu_src_a = 1'b1; v.alu_src_b = srcb; v.alu_op = code;
    return v;
  endfunction
  function automatic out_t v_alu_wb(input logic [1:0] dst);
    out_t v = '0;
    v.reg_write = 1'b1; v.reg_dst = dst; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic out_t v_mem_addr(input logic [3:0] code);
    out_t v = '0;
    v.alu_src_a = 1'b1; v.alu_src_b = 2'd2; v.alu_op = code;
    return v;
  endfunction
  function automatic out_t v_mem_rd();
    out_t v = '0;
    v.mem_read = 1'b1; v.i_or_d = 1'b1;
    return v;
  endfunction
  function automatic out_t v_mem_wb();
    out_t v = '0;
    v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic out_t v_mem_wr(input logic rdy);
    out_t v = '0;
    v.mem_write = 1'b1; v.i_or_d = 1'b1; v.instr_done = rdy;
    return v;
  endfunction
  function automatic out_t v_branch(input logic [3:0] code, input logic is_beq);
    out_t v = '0;
    v.alu_src_a = 1'b1; v.alu_op = code; v.pc_source = 2'd1;
    v.pc_write_beq = is_beq; v.pc_write_bne = !is_beq; v.instr_done = 1'b1;
    return v;
  endfunction
  function automatic out_t v_jump(input logic is_jal);
    out_t v = '0;
    v.pc_source = 2'd2; v.pc_write = 1'b1; v.instr_done = 1'b1;
    v.reg_write = is_jal; v.reg_dst = is_jal ? 2'd2 : 2'd0;
    return v;
  endfunction
  function automatic out_t v_trap(input logic [1:0] cause);
    out_t v = '0;
    v.trap = 1'b1; v.trap_cause = cause;
    return v;
  endfunction

  // Stimulus table builder: expected vector plus mem_ready for that cycle.
  task automatic add(input out_t e, input logic r);
    q_ex.push_back(e);
    q_rd.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 6'd0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== v_idle()) begin
      n_bad++; $display("FAIL reset_hold: got %h want %h", obs, v_idle());
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== v_idle()) begin
      n_bad++; $display("FAIL reset_release: got %h want %h", obs, v_idle());
    end
  endtask

  task automatic test_addi();
    op = 6'b001000;
    q_ex.delete(); q_rd.delete();
    add(v_idle(), 1'b1);
    add(v_fetch(1'b1), 1'b1);
    add(v_decode(), 1'b1);
    add(v_exec(4'b0100, 2'd2), 1'b1);
    add(v_alu_wb(2'd0), 1'b1);
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL addi[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_alu_types();
    logic [5:0] ops   [4] = '{6'b000000, 6'b001100, 6'b001101, 6'b001111};
    logic [3:0] codes [4] = '{4'b0111, 4'b0101, 4'b0110, 4'b0011};
    for (int k = 0; k < 4; k++) begin
      op = ops[k];
      q_ex.delete(); q_rd.delete();
      add(v_fetch(1'b1), 1'b1);
      add(v_decode(), 1'b0);
      add(v_exec(codes[k], (k == 0) ? 2'd0 : 2'd2), 1'b0);
      add(v_alu_wb((k == 0) ? 2'd1 : 2'd0), 1'b0);
      for (int i = 0; i < q_ex.size(); i++) begin
        mem_ready = q_rd[i]; #1;
        n_cmp++;
        if (obs !== q_ex[i]) begin
          n_bad++; $display("FAIL alu_op%0d[%0d]: got %h want %h", k, i, obs, q_ex[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_lw();
    op = 6'b100011;
    q_ex.delete(); q_rd.delete();
    add(v_fetch(1'b1), 1'b1);
    add(v_decode(), 1'b0);
    add(v_mem_addr(4'b1010), 1'b0);
    repeat (3) add(v_mem_rd(), 1'b0);
    add(v_mem_rd(), 1'b1);
    add(v_mem_wb(), 1'b0);
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL lw[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    op = 6'b101011;
    q_ex.delete(); q_rd.delete();
    add(v_fetch(1'b1), 1'b1);
    add(v_decode(), 1'b0);
    add(v_mem_addr(4'b1011), 1'b0);
    repeat (3) add(v_mem_wr(1'b0), 1'b0);
    add(v_mem_wr(1'b1), 1'b1);
    add(v_fetch(1'b0), 1'b0);
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL sw[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 6'b000100 : 6'b000101;
      q_ex.delete(); q_rd.delete();
      add(v_fetch(1'b1), 1'b1);
      add(v_decode(), 1'b0);
      add(v_branch((k == 0) ? 4'b1000 : 4'b1001, k == 0), 1'b0);
      for (int i = 0; i < q_ex.size(); i++) begin
        mem_ready = q_rd[i]; #1;
        n_cmp++;
        if (obs !== q_ex[i]) begin
          n_bad++; $display("FAIL branch%0d[%0d]: got %h want %h", k, i, obs, q_ex[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_jump();
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 6'b000011 : 6'b000010;
      q_ex.delete(); q_rd.delete();
      add(v_fetch(1'b1), 1'b1);
      add(v_decode(), 1'b1);
      add(v_jump(k == 0), 1'b1);
      for (int i = 0; i < q_ex.size(); i++) begin
        mem_ready = q_rd[i]; #1;
        n_cmp++;
        if (obs !== q_ex[i]) begin
          n_bad++; $display("FAIL jump%0d[%0d]: got %h want %h", k, i, obs, q_ex[i]);
        end
        tick();
      end
    end
  endtask

  // Long fetch wait followed by a long read wait: each wait must restart at 0.
  task automatic test_wait_clear();
    op = 6'b100011;
    q_ex.delete(); q_rd.delete();
    repeat (10) add(v_fetch(1'b0), 1'b0);
    add(v_fetch(1'b1), 1'b1);
    add(v_decode(), 1'b0);
    add(v_mem_addr(4'b1010), 1'b0);
    repeat (15) add(v_mem_rd(), 1'b0);
    add(v_mem_rd(), 1'b1);
    add(v_mem_wb(), 1'b0);
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL wait_clear[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    q_ex.delete(); q_rd.delete();
    add(v_fetch(1'b1), 1'b1);
    add(v_decode(), 1'b0);
    for (int j = 0; j < 100; j++) add(v_trap(2'd1), 1'($urandom_range(0, 1)));
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL illegal[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({trap, trap_cause} !== 3'b000) begin
      n_bad++; $display("FAIL illegal_reset: got %b want 000", {trap, trap_cause});
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_timeout();
    op = 6'b001000;
    q_ex.delete(); q_rd.delete();
    add(v_idle(), 1'b0);
    repeat (16) add(v_fetch(1'b0), 1'b0);
    add(v_trap(2'd2), 1'b0);
    add(v_trap(2'd2), 1'b1);
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL timeout[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    q_ex.delete(); q_rd.delete();
    add(v_idle(), 1'b0);
    repeat (15) add(v_fetch(1'b0), 1'b0);
    add(v_fetch(1'b1), 1'b1);
    add(v_decode(), 1'b0);
    add(v_exec(4'b0100, 2'd2), 1'b0);
    add(v_alu_wb(2'd0), 1'b0);
    repeat (4) add(v_fetch(1'b0), 1'b0);
    for (int i = 0; i < q_ex.size(); i++) begin
      mem_ready = q_rd[i]; #1;
      n_cmp++;
      if (obs !== q_ex[i]) begin
        n_bad++; $display("FAIL edge_ready[%0d]: got %h want %h", i, obs, q_ex[i]);
      end
      tick();
    end
    // Still waiting in fetch: reset mid-cycle must clear strobes at once.
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== v_idle()) begin
      n_bad++; $display("FAIL async_reset: got %h want %h", obs, v_idle());
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_types();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_wait_clear();
    test_illegal();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
